// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - opcodes, states, strobe encodings and opcode classifier for the RISC sequencer
package risc_pkg;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    localparam logic [1:0] PC_PLUS2  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_LD, C_ST, C_BEQ, C_BNE, C_JMP, C_ILL
    } op_class_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        case (op)
            OP_LD:   return C_LD;
            OP_ST:   return C_ST;
            OP_BEQ:  return C_BEQ;
            OP_BNE:  return C_BNE;
            OP_JMP:  return C_JMP;
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1001:
                     return C_ALU;
            default: return C_ILL;
        endcase
    endfunction

endpackage

// File: rtl/risc_wait_timer.sv
// rtl/risc_wait_timer.sv - saturating ready-wait counter shared by FETCH and MEM
module risc_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CW          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    logic [CW-1:0] count;

    assign expire = (count == CW'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (count_en && !expire)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/risc_seq_ctrl.sv
// rtl/risc_seq_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout
module risc_seq_ctrl
    import risc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CW          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       dest_reg,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       ram_read,
    output logic       write_enable,
    output logic       retire,
    output logic       fault
);

    state_t     state;
    logic [3:0] op_q;
    op_class_t  cls_q;
    logic       waiting;
    logic       ready;
    logic       expire;

    assign cls_q   = op_class(op_q);
    assign waiting = (state == S_FETCH) || (state == S_MEM);
    assign ready   = (state == S_FETCH) ? imem_ready : dmem_ready;

    // Any ready or any non-wait state clears, so the count is zero on entry to FETCH/MEM.
    risc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CW(CW)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!waiting || ready),
        .count_en (waiting && !ready),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready)  state <= S_DECODE;
                    else if (expire) state <= S_FAULT;
                end
                S_DECODE: begin
                    op_q  <= opcode;
                    state <= (op_class(opcode) == C_ILL) ? S_FAULT : S_EXEC;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_ALU:       state <= S_WB;
                        C_LD, C_ST:  state <= S_MEM;
                        default:     state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready)  state <= (cls_q == C_LD) ? S_WB : S_FETCH;
                    else if (expire) state <= S_FAULT;
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS2;
        alu_src      = 1'b0;
        alu_op       = ALU_ADD;
        dest_reg     = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        ram_read     = 1'b0;
        write_enable = 1'b0;
        retire       = 1'b0;
        fault        = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_ALU: alu_op = ALU_FUNC;
                        C_LD, C_ST: alu_src = 1'b1;
                        C_BEQ, C_BNE: begin
                            alu_op   = ALU_SUB;
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            if ((cls_q == C_BEQ) == zero) pc_src = PC_BRANCH;
                        end
                        C_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                            retire   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (cls_q == C_LD) begin
                        ram_read = 1'b1;
                    end else begin
                        write_enable = 1'b1;
                        alu_src      = 1'b1;
                        pc_write     = dmem_ready;
                        retire       = dmem_ready;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    mem_to_reg = (cls_q == C_LD);
                    dest_reg   = (cls_q != C_LD);
                end
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// tb/tb_risc_seq_ctrl.sv - randomized and directed cycle-trace checks of risc_seq_ctrl
module tb_risc_seq_ctrl;

    localparam int T = 15;

    localparam logic [14:0] IMR    = 15'h4000;
    localparam logic [14:0] IRW    = 15'h2000;
    localparam logic [14:0] PCW    = 15'h1000;
    localparam logic [14:0] PCS_J  = 15'h0800;
    localparam logic [14:0] PCS_BR = 15'h0400;
    localparam logic [14:0] ASRC   = 15'h0200;
    localparam logic [14:0] AFN    = 15'h0100;
    localparam logic [14:0] ASUB   = 15'h0080;
    localparam logic [14:0] DEST   = 15'h0040;
    localparam logic [14:0] M2R    = 15'h0020;
    localparam logic [14:0] RW     = 15'h0010;
    localparam logic [14:0] RR     = 15'h0008;
    localparam logic [14:0] WE     = 15'h0004;
    localparam logic [14:0] RET    = 15'h0002;
    localparam logic [14:0] FLT    = 15'h0001;

    typedef struct {
        logic [14:0] exp;
        logic        imr;
        logic        dmr;
        logic [3:0]  opc;
        logic        z;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = '0;
    logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       imem_req, ir_write, pc_write, alu_src, dest_reg, mem_to_reg;
    logic       reg_write, ram_read, write_enable, retire, fault;
    logic [1:0] pc_src, alu_op;
    logic [14:0] obs;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    risc_seq_ctrl #(.MEM_TIMEOUT(T), .CW(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
        .dest_reg(dest_reg), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .ram_read(ram_read), .write_enable(write_enable), .retire(retire),
        .fault(fault)
    );

    assign obs = {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op, dest_reg,
                  mem_to_reg, reg_write, ram_read, write_enable, retire, fault};

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic add(input logic [14:0] e, input logic imr, input logic dmr,
                       input logic [3:0] opc, input logic z);
        cyc_t c;
        c.exp = e; c.imr = imr; c.dmr = dmr; c.opc = opc; c.z = z;
        q.push_back(c);
    endtask

    // Expected cycle trace of one instruction, built from the instruction-level rules.
    task automatic plan(input logic [3:0] op, input logic z, input int iw, input int dw,
                        output bit faulted);
        bit taken;
        faulted = 1'b0;
        for (int i = 0; i < iw && i <= T; i++) add(IMR, 1'b0, r1(), r4(), r1());
        if (iw > T) begin faulted = 1'b1; return; end
        add(IMR | IRW, 1'b1, r1(), r4(), r1());
        add('0, r1(), r1(), op, r1());
        if (op == 4'd10 || op >= 4'd14) begin faulted = 1'b1; return; end
        if (op >= 4'd2 && op <= 4'd9) begin
            add(AFN, r1(), r1(), r4(), r1());
            add(RW | PCW | RET | DEST, r1(), r1(), r4(), r1());
        end else if (op == 4'd11 || op == 4'd12) begin
            taken = (op == 4'd11) ? z : !z;
            add(ASUB | PCW | RET | (taken ? PCS_BR : 15'h0), r1(), r1(), r4(), z);
        end else if (op == 4'd13) begin
            add(PCW | PCS_J | RET, r1(), r1(), r4(), r1());
        end else begin
            add(ASRC, r1(), r1(), r4(), r1());
            for (int i = 0; i < dw && i <= T; i++)
                add((op == 4'd0) ? RR : (WE | ASRC), r1(), 1'b0, r4(), r1());
            if (dw > T) begin faulted = 1'b1; return; end
            if (op == 4'd0) begin
                add(RR, r1(), 1'b1, r4(), r1());
                add(RW | PCW | RET | M2R, r1(), r1(), r4(), r1());
            end else begin
                add(WE | ASRC | PCW | RET, r1(), 1'b1, r4(), r1());
            end
        end
    endtask

    task automatic check(input string tag, input int idx, input logic [14:0] e);
        n_checks++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s cyc%0d: got %h expected %h", tag, idx, obs, e);
    endtask

    task automatic run_q(input string tag);
        cyc_t c;
        int   idx = 1;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #2;
            rst = 1'b0;
            imem_ready = c.imr; dmem_ready = c.dmr; opcode = c.opc; zero = c.z;
            #3;
            check(tag, idx, c.exp);
            idx++;
        end
    endtask

    task automatic do_reset(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            rst = 1'b1;
            imem_ready = r1(); dmem_ready = r1(); opcode = r4(); zero = r1();
            #3;
            check(tag, i, '0);
        end
    endtask

    task automatic fault_hold();
        for (int i = 0; i < 4; i++) add(FLT, r1(), r1(), r4(), r1());
    endtask

    initial begin
        bit f;
        logic [3:0] op;

        do_reset("reset", 2);

        plan(4'b0010, 1'b0, 0, 0, f);
        plan(4'b0010, 1'b0, 0, 0, f);
        run_q("add");

        plan(4'b0000, 1'b0, 0, 3, f);
        plan(4'b0001, 1'b0, 1, 0, f);
        run_q("ld_st");

        plan(4'b1011, 1'b1, 0, 0, f);
        plan(4'b1100, 1'b1, 0, 0, f);
        plan(4'b1011, 1'b0, 0, 0, f);
        plan(4'b1100, 1'b0, 0, 0, f);
        plan(4'b1101, 1'b0, 0, 0, f);
        run_q("branch");

        plan(4'b0011, 1'b0, T + 1, 0, f);
        fault_hold();
        run_q("imem_timeout");
        do_reset("fault_reset", 1);

        plan(4'b0011, 1'b0, T, 0, f);
        plan(4'b0000, 1'b0, 0, T, f);
        run_q("ready_at_threshold");

        plan(4'b0001, 1'b0, 0, T + 1, f);
        fault_hold();
        run_q("dmem_timeout");
        do_reset("fault_reset2", 1);

        plan(4'b1110, 1'b0, 0, 0, f);
        fault_hold();
        run_q("illegal");
        do_reset("illegal_reset", 1);

        plan(4'b0001, 1'b0, 0, 5, f);
        repeat (4) void'(q.pop_back());
        run_q("st_abort");
        do_reset("st_abort_rst", 1);
        plan(4'b0100, 1'b0, 0, 0, f);
        run_q("after_abort");

        for (int k = 0; k < 40; k++) begin
            do op = r4(); while (op == 4'd10 || op >= 4'd14);
            plan(op, r1(), $urandom_range(0, 3), $urandom_range(0, 3), f);
        end
        run_q("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/risc_seq_ctrl.md
Name: risc_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit RISC Harvard datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes (PC, IR, register file, ALU, data RAM) only in the proper state.
- Waits on ready handshakes from instruction and data memory, with a bounded timeout.
- Sits beside the bus datapath in the cpu top. Replaces the single-cycle control path when memories have variable latency.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles a FETCH or MEM wait may last with ready low before FAULT (1..255).
- CW, 8, width of the wait counter; must satisfy 2**CW > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  instruction opcode from the IR output; sampled in DECODE.
- zero  in  1  ALU zero flag; valid in EXEC.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data RAM access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC.
- pc_src  out  2  PC source: 00 = PC+2, 01 = branch target, 10 = jump target.
- alu_src  out  1  ALU B operand: 1 = immediate, 0 = register.
- alu_op  out  2  00 = add, 01 = sub, 10 = R-type function from opcode.
- dest_reg  out  1  destination register select: 1 = rd (R-type), 0 = rt (load).
- mem_to_reg  out  1  write-back source: 1 = RAM, 0 = ALU.
- reg_write  out  1  register file write strobe.
- ram_read  out  1  data RAM read strobe.
- write_enable  out  1  data RAM write strobe.
- retire  out  1  one-cycle pulse when an instruction completes.
- fault  out  1  sticky; high while in FAULT.

Behaviour:
- Reset:
  - While rst=1, every output is 0, including strobes in the current cycle.
  - Next state is FETCH; op_q and the wait counter are cleared.
  - Reset mid-instruction abandons it, with no partial PC or register write.
- Opcode classes:
  - LD = 0000, ST = 0001.
  - ALU ops = 0010–1001.
  - BEQ = 1011, BNE = 1100, JMP = 1101.
  - Illegal = 1010, 1110, 1111.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_write=1, go to DECODE.
- DECODE:
  - Latch opcode into op_q; no strobes.
  - Illegal opcode → FAULT.
  - Otherwise → EXEC.
- EXEC, by class:
  - ALU op: alu_op=10, alu_src=0; → WB.
  - LD/ST: alu_op=00, alu_src=1 (address calculation); → MEM.
  - BEQ/BNE: alu_op=01. pc_write=1; pc_src=01 if taken, else 00. Taken means BEQ with zero=1, or BNE with zero=0. retire=1; → FETCH.
  - JMP: pc_write=1, pc_src=10, retire=1; → FETCH.
- MEM:
  - LD: hold ram_read=1 until dmem_ready, then → WB.
  - ST: hold write_enable=1 and alu_src=1 until dmem_ready. In the dmem_ready cycle also pc_write=1, pc_src=00, retire=1; → FETCH.
- WB:
  - reg_write=1, pc_write=1, pc_src=00, retire=1.
  - LD: mem_to_reg=1, dest_reg=0. ALU op: mem_to_reg=0, dest_reg=1.
  - → FETCH.
- Latency with zero-wait memories (ready high on the first cycle):
  - ALU op: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - BEQ/BNE/JMP: 3 cycles.
  - Each ready-low cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments on each cycle in that state with ready=0.
  - If the count equals MEM_TIMEOUT and ready is still 0, → FAULT.
  - Ready=1 in the same cycle as the threshold wins: normal advance.
- FAULT:
  - fault=1, all other outputs 0.
  - Exit only by rst.
- Outputs are decoded combinationally from the state register and op_q; no output depends combinationally on opcode.
- Exceptions: zero (EXEC branch), imem_ready (FETCH) and dmem_ready (MEM) act combinationally within their state.

Decomposition:
- Package risc_pkg:
  - Opcode localparams.
  - State enum: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT.
  - pc_src encodings and alu_op encodings.
  - Opcode-class helper function.
- One sub-module, risc_wait_timer:
  - Ports: clk, rst, clear, count_en, expire.
  - Parameterised by MEM_TIMEOUT and CW.
  - Instantiated once; shared by FETCH and MEM.

Test Plan:
1. Reset, then ADD (0010) with imem_ready and dmem_ready tied 1:
   - ir_write at cycle 1, reg_write + dest_reg=1 + pc_write + retire at cycle 4.
   - Back in FETCH at cycle 5.
2. LD (0000) with dmem_ready low 3 cycles:
   - ram_read held 4 cycles, then WB with mem_to_reg=1, dest_reg=0.
   - Total 8 cycles to retire.
3. BEQ with zero=1 → pc_src=01 at cycle 3. BNE with zero=1 → pc_src=00 at cycle 3. JMP → pc_src=10.
4. imem_ready held 0 with MEM_TIMEOUT=15:
   - Enters FAULT after 15 waiting cycles; fault=1, all strobes 0, persists until rst.
   - Repeat with ready rising exactly at the threshold → no fault.
5. Opcode 1110 → FAULT after DECODE with no reg_write or write_enable ever pulsed.
6. Assert rst during the ST MEM wait:
   - write_enable drops to 0 in the rst cycle.
   - Next instruction starts from FETCH with no retire pulse from the aborted ST.
